// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with optional parity.
//
// The receiver oversamples the line at 8x the bit rate. After it sees a
// falling edge it confirms the start bit at mid-bit. It then samples each
// data bit, the optional parity bit and the stop bit at the middle of the bit.
//
// Parameters
//   CLK_FREQ   input clock frequency in Hz
//   BAUD_RATE  serial bit rate in bit/s
//   PARITY     "NONE", "EVEN" or "ODD"
//
// Ports
//   clk       system clock, rising-edge
//   rst       asynchronous active-high reset
//   rx        serial input, idles high, asynchronous to clk
//   rx_data   last correctly received byte
//   rx_rdy    one-clk pulse when rx_data is updated
//   rx_err    one-clk pulse on a framing or parity error
//   tx_bd_en  one-clk strobe at 1x baud, for pacing a transmitter

module uart_rx #(
  parameter int    CLK_FREQ  = 100_000_000,
  parameter int    BAUD_RATE = 115200,
  parameter string PARITY    = "NONE"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_err,
  output logic       tx_bd_en
);

  localparam int DIV8    = CLK_FREQ / (BAUD_RATE * 8);
  localparam int BCW     = (DIV8 > 1) ? $clog2(DIV8) : 1;
  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");

  if (DIV8 < 2) begin : g_div8_check
    $error("uart_rx: CLK_FREQ/(BAUD_RATE*8) must be at least 2");
  end

  if (!(PARITY == "NONE" || PARITY == "EVEN" || PARITY == "ODD")) begin : g_parity_check
    $error("uart_rx: PARITY must be NONE, EVEN or ODD");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } state_t;

  logic [BCW-1:0] bcnt;
  logic [2:0]     tick;
  logic           rx_bd_en;
  logic           sync1;
  logic           rxs;

  state_t         state, state_n;
  logic [2:0]     tc, tc_n;
  logic [2:0]     bidx, bidx_n;
  logic [7:0]     shreg, shreg_n;
  logic           par_ok, par_ok_n;
  logic [7:0]     data_n;
  logic           rdy_n, err_n;

  // 8x oversampling tick generator, plus a divide-by-8 to get the 1x strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
      tick <= '0;
    end else begin
      if (rx_bd_en) begin
        bcnt <= '0;
        tick <= tick + 3'd1;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  assign rx_bd_en = (bcnt == BCW'(DIV8 - 1));
  assign tx_bd_en = rx_bd_en && (tick == 3'd7);

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tc      <= '0;
      bidx    <= '0;
      shreg   <= '0;
      par_ok  <= 1'b0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_n;
      tc      <= tc_n;
      bidx    <= bidx_n;
      shreg   <= shreg_n;
      par_ok  <= par_ok_n;
      rx_data <= data_n;
      rx_rdy  <= rdy_n;
      rx_err  <= err_n;
    end
  end

  // Next-state logic. Everything advances only on oversampling ticks.
  // In DATA, PAR and STOP, tc wraps 7->0 on its own, so sampling at tc==7
  // also opens the next bit window.
  always_comb begin
    state_n  = state;
    tc_n     = tc;
    bidx_n   = bidx;
    shreg_n  = shreg;
    par_ok_n = par_ok;
    data_n   = rx_data;
    rdy_n    = 1'b0;
    err_n    = 1'b0;
    if (rx_bd_en) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            tc_n    = '0;
          end
        end
        START: begin
          if (tc == 3'd3) begin
            if (!rxs) begin
              state_n  = DATA;
              tc_n     = '0;
              bidx_n   = '0;
              par_ok_n = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tc_n = tc + 3'd1;
          end
        end
        DATA: begin
          tc_n = tc + 3'd1;
          if (tc == 3'd7) begin
            shreg_n = {rxs, shreg[7:1]};
            bidx_n  = bidx + 3'd1;
            if (bidx == 3'd7) begin
              state_n = PAR_EN ? PAR : STOP;
            end
          end
        end
        PAR: begin
          tc_n = tc + 3'd1;
          if (tc == 3'd7) begin
            par_ok_n = (((^shreg) ^ rxs) == PAR_ODD);
            state_n  = STOP;
          end
        end
        STOP: begin
          tc_n = tc + 3'd1;
          if (tc == 3'd7) begin
            if (!rxs) begin
              err_n   = 1'b1;
              state_n = WAIT_IDLE;
            end else if (!par_ok) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end else begin
              data_n  = shreg;
              rdy_n   = 1'b1;
              state_n = IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
//
// There are two receivers. dut_n uses no parity and dut_e uses even parity.
// Each one has its own serial line. The bench paces the frames with tx_bd_en.
// Before it sends a frame, the bench adds the expected result (good byte or
// error) to a per-receiver queue. A compare process then checks every
// rx_rdy/rx_err pulse against that queue. It also checks the pulse latency,
// and it checks rx_data against the last good byte on every cycle.

module tb_uart_rx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 31250;
  localparam int DIV8      = CLK_FREQ / (BAUD_RATE * 8);

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         stamp;
    int         par;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx_n, rx_e;
  logic [7:0] data_n, data_e;
  logic       rdy_n, rdy_e;
  logic       err_n, err_e;
  logic       tx_n, tx_e;

  int         checks;
  int         errors;
  int         cyc;
  exp_t       q_n[$];
  exp_t       q_e[$];
  logic [7:0] model_n, model_e;
  logic       prev_n, prev_e;
  exp_t       ev;
  int         period;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY("NONE")) dut_n (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx_n),
    .rx_data (data_n),
    .rx_rdy  (rdy_n),
    .rx_err  (err_n),
    .tx_bd_en(tx_n)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY("EVEN")) dut_e (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx_e),
    .rx_data (data_e),
    .rx_rdy  (rdy_e),
    .rx_err  (err_e),
    .tx_bd_en(tx_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkEvent(input string tag, input exp_t e, input logic rdy, input logic err,
                            input logic prev);
    int lat;
    int nominal;
    lat     = cyc - e.stamp;
    nominal = (4 + 8 * (9 + e.par)) * DIV8 + 3;
    checkOutput({"pulse_kind_", tag}, {30'd0, rdy, err}, e.is_err ? 32'd1 : 32'd2);
    checkOutput({"pulse_one_clk_", tag}, {31'd0, prev}, 32'd0);
    checkOutput({"latency_", tag},
                (lat >= nominal - DIV8 - 1 && lat <= nominal + DIV8 + 1) ? nominal : lat, nominal);
  endtask

  // Compare process: checks the receiver outputs against the model on every cycle
  initial begin
    prev_n  = 1'b0;
    prev_e  = 1'b0;
    model_n = 8'h00;
    model_e = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        q_n.delete();
        q_e.delete();
        model_n = 8'h00;
        model_e = 8'h00;
        prev_n  = 1'b0;
        prev_e  = 1'b0;
        checkOutput("reset_outputs_n", {21'd0, data_n, rdy_n, err_n, tx_n}, 32'd0);
        checkOutput("reset_outputs_e", {21'd0, data_e, rdy_e, err_e, tx_e}, 32'd0);
      end else begin
        if (rdy_n || err_n) begin
          if (q_n.size() == 0) begin
            checkOutput("unexpected_pulse_n", {30'd0, rdy_n, err_n}, 32'd0);
          end else begin
            ev = q_n.pop_front();
            checkEvent("n", ev, rdy_n, err_n, prev_n);
            if (!ev.is_err) model_n = ev.data;
          end
        end
        if (rdy_e || err_e) begin
          if (q_e.size() == 0) begin
            checkOutput("unexpected_pulse_e", {30'd0, rdy_e, err_e}, 32'd0);
          end else begin
            ev = q_e.pop_front();
            checkEvent("e", ev, rdy_e, err_e, prev_e);
            if (!ev.is_err) model_e = ev.data;
          end
        end
        checkOutput("rx_data_n", {24'd0, data_n}, {24'd0, model_n});
        checkOutput("rx_data_e", {24'd0, data_e}, {24'd0, model_e});
        prev_n = rdy_n || err_n;
        prev_e = rdy_e || err_e;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_n = v;
    else rx_e = v;
  endtask

  // Advances to the next negedge at which the 1x baud strobe is high
  task automatic wait_tx();
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("tx_bd_timeout", n, 0);
  endtask

  task automatic idle(input int which, input int bits);
    set_rx(which, 1'b1);
    for (int i = 0; i < bits; i++) wait_tx();
  endtask

  // Sends one frame. Dut_e frames carry a parity bit. The expected outcome
  // comes straight from the frame rules.
  task automatic applyStimulus(input int which, input logic [7:0] data, input logic par_bit,
                               input logic stop_bit);
    exp_t e;
    e.data   = data;
    e.par    = (which == 1) ? 1 : 0;
    e.is_err = !stop_bit || (which == 1 && (((^data) ^ par_bit) != 1'b0));
    e.stamp  = cyc;
    if (which == 0) q_n.push_back(e);
    else q_e.push_back(e);
    set_rx(which, 1'b0);
    wait_tx();
    for (int i = 0; i < 8; i++) begin
      set_rx(which, data[i]);
      wait_tx();
    end
    if (which == 1) begin
      set_rx(which, par_bit);
      wait_tx();
    end
    set_rx(which, stop_bit);
    wait_tx();
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 0) ? q_n.size() : q_e.size()) != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", (n < 1000) ? 32'd0 : 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] partial;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rx_n   = 1'b1;
    rx_e   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", {24'd0, data_n}, 32'h00);
    checkOutput("reset_tx_bd_en", {31'd0, tx_n}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // 1x strobe period is 8 ticks of DIV8 clocks
    wait_tx();
    period = 0;
    do begin
      @(negedge clk);
      period++;
    end while (!tx_n && period < 100);
    checkOutput("tx_bd_period", period, 32);

    // Single frame after a long idle
    idle(0, 11);
    applyStimulus(0, 8'h66, 1'b0, 1'b1);
    drain(0);
    checkOutput("first_byte", {24'd0, data_n}, 32'h66);

    // Back-to-back frames
    idle(0, 1);
    applyStimulus(0, 8'h66, 1'b0, 1'b1);
    applyStimulus(0, 8'hA5, 1'b0, 1'b1);
    drain(0);
    checkOutput("back_to_back_byte", {24'd0, data_n}, 32'hA5);

    // Start-bit glitch of two oversampling ticks
    idle(0, 1);
    set_rx(0, 1'b0);
    repeat (2 * DIV8) @(negedge clk);
    idle(0, 3);
    applyStimulus(0, 8'h5A, 1'b0, 1'b1);
    drain(0);
    checkOutput("after_glitch_byte", {24'd0, data_n}, 32'h5A);

    // Framing error keeps the old byte, then the receiver recovers
    idle(0, 1);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0);
    checkOutput("framing_err_keeps_data", {24'd0, data_n}, 32'h5A);
    idle(0, 1);
    applyStimulus(0, 8'h81, 1'b0, 1'b1);
    drain(0);
    checkOutput("recovered_byte", {24'd0, data_n}, 32'h81);

    // Even parity: good and bad parity bit
    idle(1, 2);
    applyStimulus(1, 8'h07, 1'b1, 1'b1);
    drain(1);
    checkOutput("even_good_byte", {24'd0, data_e}, 32'h07);
    idle(1, 1);
    applyStimulus(1, 8'h07, 1'b0, 1'b1);
    drain(1);
    checkOutput("even_bad_keeps_data", {24'd0, data_e}, 32'h07);

    // Reset in the middle of data bit 4
    idle(0, 1);
    partial = 8'h55;
    set_rx(0, 1'b0);
    wait_tx();
    for (int i = 0; i < 4; i++) begin
      set_rx(0, partial[i]);
      wait_tx();
    end
    set_rx(0, partial[4]);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    set_rx(0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("midframe_reset_data", {24'd0, data_n}, 32'h00);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(0, 11);
    applyStimulus(0, 8'h55, 1'b0, 1'b1);
    drain(0);
    checkOutput("after_reset_byte", {24'd0, data_n}, 32'h55);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
